conv_pixel_sequencer: RTL and testbench



---
 rtl/conv_pixel_sequencer_if.sv | 29 ++
 rtl/conv_pixel_sequencer.sv | 129 ++++++++++++
 tb/tb_conv_pixel_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pixel_sequencer_if.sv
// Output-pixel bus between the sequencer and the output write stage.
interface conv_pixel_sequencer_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ADDR_W  = 10
) ();
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic [ADDR_W-1:0]  out_addr;

    // Sequencer side: presents finished pixels, receives ready.
    modport master (
        output out_valid,
        output out_row,
        output out_col,
        output out_addr,
        input  out_ready
    );

    // Write-stage side: consumes pixels, drives ready.
    modport slave (
        input  out_valid,
        input  out_row,
        input  out_col,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/conv_pixel_sequencer.sv
// Raster-order output-pixel sequencer: runs the window counter once per pixel
// and hands each finished pixel's coordinates to the write stage.
module conv_pixel_sequencer #(
    parameter int unsigned OUT_W   = 28,
    parameter int unsigned OUT_H   = 28,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic                   abort,
    input  logic                   tile_tick,
    output logic                   cnt_start,
    output logic                   busy,
    output logic                   done,
    conv_pixel_sequencer_if.master pix
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(OUT_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [ADDR_W-1:0]  r_addr;
    logic [COORD_W-1:0] w_row_nxt;
    logic [COORD_W-1:0] w_col_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_last;
    logic               r_cnt_start;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // Next state and raster position; abort outranks every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_addr_nxt  = r_addr;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_addr_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        w_state_nxt = S_RUN;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_addr_nxt  = '0;
                    end
                end
                S_RUN: begin
                    if (tile_tick) begin
                        w_state_nxt = S_OUT;
                    end
                end
                S_OUT: begin
                    if (pix.out_ready) begin
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            if (r_col == COL_LAST) begin
                                w_col_nxt = '0;
                                w_row_nxt = r_row + COORD_W'(1);
                            end else begin
                                w_col_nxt = r_col + COORD_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, position and outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_cnt_start <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_addr      <= w_addr_nxt;
            r_cnt_start <= (w_state_nxt == S_RUN);
            r_valid     <= (w_state_nxt == S_OUT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign cnt_start     = r_cnt_start;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pix.out_valid = r_valid;
    assign pix.out_row   = r_row;
    assign pix.out_col   = r_col;
    assign pix.out_addr  = r_addr;

endmodule

// File: tb/tb_conv_pixel_sequencer.sv
// Bench for conv_pixel_sequencer: a 4x3 map driven by a window-counter model
// and checked every cycle against a pixel-index reference, plus a 1x1 map.
module tb_conv_pixel_sequencer;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int MAX = 4;
    localparam int CW  = 8;
    localparam int AW  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, go, abort, inj_tick, tile_tick, cnt_start, busy, done;
    logic go1, tick1, abort1, cnt_start1, busy1, done1;

    conv_pixel_sequencer_if #(.COORD_W(CW), .ADDR_W(AW)) pif ();
    conv_pixel_sequencer_if #(.COORD_W(CW), .ADDR_W(AW)) pif1 ();

    conv_pixel_sequencer #(.OUT_W(W), .OUT_H(H), .COORD_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .tile_tick(tile_tick),
        .cnt_start(cnt_start), .busy(busy), .done(done), .pix(pif)
    );

    conv_pixel_sequencer #(.OUT_W(1), .OUT_H(1), .COORD_W(CW), .ADDR_W(AW)) dut1 (
        .clk(clk), .reset_n(reset_n), .go(go1), .abort(abort1), .tile_tick(tick1),
        .cnt_start(cnt_start1), .busy(busy1), .done(done1), .pix(pif1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Window counter: tick appears MAX cycles after start rises; start low clears it.
    int   ctr_cnt  = 0;
    logic ctr_tick = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_cnt  <= 0;
            ctr_tick <= 1'b0;
        end else if (!cnt_start) begin
            ctr_cnt  <= 0;
            ctr_tick <= 1'b0;
        end else begin
            ctr_cnt  <= ctr_cnt + 1;
            ctr_tick <= (ctr_cnt == MAX - 1);
        end
    end
    assign tile_tick = ctr_tick | inj_tick;

    // Reference: phase (0 idle, 1 waiting for tick, 2 presenting, 3 done) and pixel index.
    int m_mode = 0;
    int m_p    = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0;
            m_p    <= 0;
        end else if (abort) begin
            m_mode <= 0;
            m_p    <= 0;
        end else begin
            case (m_mode)
                0: if (go) begin m_mode <= 1; m_p <= 0; end
                1: if (tile_tick) m_mode <= 2;
                2: if (pif.out_ready) begin
                       if (m_p == N - 1) m_mode <= 3;
                       else begin m_mode <= 1; m_p <= m_p + 1; end
                   end
                default: m_mode <= 0;
            endcase
        end
    end

    // Every-cycle comparison of the 4x3 instance against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cnt_start", cnt_start, m_mode == 1);
            chk("out_valid", pif.out_valid, m_mode == 2);
            chk("busy", busy, m_mode != 0);
            chk("done", done, m_mode == 3);
            chk("out_row", pif.out_row, m_p / W);
            chk("out_col", pif.out_col, m_p % W);
            chk("out_addr", pif.out_addr, m_p);
        end
    end

    // Per-frame observations filled by run_frame.
    int vfirst[16], vlen[16], vrow[16], vcol[16];
    int n_px, done_cnt, done_cyc, end_cyc, g;

    task automatic run_frame(input int stall_addr, input int stall_len,
                             input int abort_addr, input bit spur);
        int  stall_left;
        int  a;
        bit  fin;
        for (int i = 0; i < 16; i++) begin
            vfirst[i] = -1; vlen[i] = 0; vrow[i] = -1; vcol[i] = -1;
        end
        n_px = 0; done_cnt = 0; done_cyc = -1; end_cyc = -1;
        stall_left = 0; fin = 1'b0;
        pif.out_ready = 1'b1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        g = cyc;
        for (int t = 0; t < 400; t++) begin
            abort = 1'b0; inj_tick = 1'b0; go = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) pif.out_ready = 1'b1;
            end
            if (!busy) begin
                fin = 1'b1; end_cyc = cyc;
                break;
            end
            if (pif.out_valid) begin
                a = int'(pif.out_addr) & 15;
                if (vlen[a] == 0) begin
                    vfirst[a] = cyc; vrow[a] = int'(pif.out_row); vcol[a] = int'(pif.out_col);
                    n_px++;
                end
                vlen[a]++;
                if (a == abort_addr) abort = 1'b1;
                else if (a == stall_addr && vlen[a] == 1) begin
                    pif.out_ready = 1'b0; stall_left = stall_len;
                end
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                if (spur) inj_tick = 1'b1;
            end
            if (spur && busy) go = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        abort = 1'b0; inj_tick = 1'b0; go = 1'b0; pif.out_ready = 1'b1;
        chk("frame_finished", fin, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        reset_n = 1'b0; go = 1'b0; abort = 1'b0; inj_tick = 1'b0; pif.out_ready = 1'b1;
        go1 = 1'b0; tick1 = 1'b0; abort1 = 1'b0; pif1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", pif.out_valid, 0);
        chk("rst_addr", pif.out_addr, 0);
        chk("rst_cnt_start", cnt_start, 0);

        // Ticks in IDLE must not start anything.
        inj_tick = 1'b1;
        repeat (4) @(negedge clk);
        inj_tick = 1'b0;
        chk("idle_tick_busy", busy, 0);
        chk("idle_tick_valid", pif.out_valid, 0);

        // 1x1 map: single pixel goes straight to DONE.
        go1 = 1'b1; @(negedge clk); go1 = 1'b0;
        @(negedge clk);
        chk("1x1_cnt_start", cnt_start1, 1);
        tick1 = 1'b1; @(negedge clk); tick1 = 1'b0;
        chk("1x1_valid", pif1.out_valid, 1);
        chk("1x1_addr", pif1.out_addr, 0);
        chk("1x1_done_early", done1, 0);
        @(negedge clk);
        chk("1x1_valid_after", pif1.out_valid, 0);
        chk("1x1_done", done1, 1);
        @(negedge clk);
        chk("1x1_done_len", done1, 0);
        chk("1x1_idle", busy1, 0);

        // Full frame with ready held high.
        run_frame(-1, 0, -1, 1'b0);
        chk("A_pixels", n_px, 12);
        chk("A_done_cnt", done_cnt, 1);
        chk("A_done_cyc", done_cyc - g, 72);
        chk("A_first_valid", vfirst[0] - g, 5);
        for (int i = 1; i < N; i++) begin
            chk("A_period", vfirst[i] - vfirst[i-1], 6);
            chk("A_valid_len", vlen[i], 1);
        end
        chk("A_row3", vrow[3], 0);
        chk("A_col3", vcol[3], 3);
        chk("A_row4", vrow[4], 1);
        chk("A_col4", vcol[4], 0);
        chk("A_row11", vrow[11], 2);
        chk("A_col11", vcol[11], 3);

        // Five-cycle stall on addr 5.
        run_frame(5, 5, -1, 1'b0);
        chk("B_hold_len", vlen[5], 6);
        chk("B_row5", vrow[5], 1);
        chk("B_col5", vcol[5], 1);
        chk("B_late", vfirst[6] - vfirst[5], 11);
        chk("B_after", vfirst[7] - vfirst[6], 6);
        chk("B_done_cyc", done_cyc - g, 77);

        // Abort while presenting addr 7.
        run_frame(-1, 0, 7, 1'b0);
        chk("C_done_cnt", done_cnt, 0);
        chk("C_pixels", n_px, 8);
        chk("C_idle_next", end_cyc - vfirst[7], 1);

        // Restart after abort, with spurious go in RUN/OUT and tick in DONE.
        run_frame(-1, 0, -1, 1'b1);
        chk("D_first_addr0", vfirst[0] - g, 5);
        chk("D_row0", vrow[0], 0);
        chk("D_pixels", n_px, 12);
        chk("D_done_cnt", done_cnt, 1);
        chk("D_done_cyc", done_cyc - g, 72);

        // Asynchronous reset in the middle of RUN.
        pif.out_ready = 1'b1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (pif.out_valid && pif.out_addr == AW'(9)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("R_found_addr9", found, 1);
        @(negedge clk);
        chk("R_run_cnt_start", cnt_start, 1);
        chk("R_run_row", pif.out_row, 2);
        chk("R_run_col", pif.out_col, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("R_valid", pif.out_valid, 0);
        chk("R_cnt_start", cnt_start, 0);
        chk("R_busy", busy, 0);
        chk("R_done", done, 0);
        chk("R_addr", pif.out_addr, 0);
        chk("R_row", pif.out_row, 0);
        @(negedge clk); inj_tick = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        inj_tick = 1'b0;
        chk("R_tick_ignored", pif.out_valid, 0);
        chk("R_still_idle", busy, 0);

        // Randomized traffic, checked every cycle against the reference.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            go            = ($urandom_range(0, 7) == 0);
            abort         = ($urandom_range(0, 149) == 0);
            inj_tick      = ($urandom_range(0, 24) == 0);
            pif.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        go = 1'b0; abort = 1'b0; inj_tick = 1'b0; pif.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
